// File: rtl/rf_write_arbiter_if.sv
// Requester-side bus of the register-file write arbiter.
//
// Handshake: requester i raises req_valid[i] with req_addr/req_data (and
// req_lock) and holds valid/addr/data stable until req_ready[i] is seen
// high. A transfer happens on a rising clk edge where req_valid[i] and
// req_ready[i] are both high. req_ready is combinational, at most one bit is
// set per cycle, and no requester's ready depends on another's ready. The
// accepted write appears on rf_we/rf_addr/rf_data/grant_id one cycle later.
interface rf_write_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
) ();
    localparam int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_lock;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    rf_we;
    logic [ADDR_W-1:0]       rf_addr;
    logic [DATA_W-1:0]       rf_data;
    logic [GID_W-1:0]        grant_id;
    logic                    locked;

    // Requesters plus the observer of the RF write port.
    modport master (
        output req_valid, req_lock, req_addr, req_data,
        input  req_ready, rf_we, rf_addr, rf_data, grant_id, locked
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_lock, req_addr, req_data,
        output req_ready, rf_we, rf_addr, rf_data, grant_id, locked
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among
// N_REQ requesters, with short locked bursts (up to MAX_LOCK grants while
// others wait). The accepted write is registered onto rf_we/rf_addr/rf_data.
// Optional feature macro: RF_ARB_STATS_EN adds stat_clr / grant_cnt
// (per-requester saturating 8-bit transfer counters).
module rf_write_arbiter #(
    parameter int N_REQ    = 3,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 4,
    parameter int MAX_LOCK = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rf_write_arbiter_if.slave      bus
`ifdef RF_ARB_STATS_EN
    ,
    input  logic                   stat_clr,
    output logic [N_REQ*8-1:0]     grant_cnt
`endif
);
    localparam int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    // locked mirrors the state register, so it doubles as the FSM debug view.
    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t             state;
    logic [GID_W-1:0]   last_grant;
    logic [CNT_W-1:0]   lock_cnt;

    logic               rr_found;
    logic [GID_W-1:0]   rr_idx;
    logic [GID_W-1:0]   scan_idx;
    logic               others_valid;
    logic               at_max;
    logic               rr_mode;
    logic               grant_en;
    logic [GID_W-1:0]   grant_idx;
    logic [N_REQ-1:0]   ready_vec;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_lock;

    // Round-robin search: first valid requester after last_grant, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        scan_idx = last_grant;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = (scan_idx == GID_W'(N_REQ - 1)) ? '0 : scan_idx + 1'b1;
            if (!rr_found && bus.req_valid[scan_idx]) begin
                rr_found = 1'b1;
                rr_idx   = scan_idx;
            end
        end
    end

    // Grant decision: RR when idle or when a full burst must yield, else owner only.
    always_comb begin
        others_valid = |(bus.req_valid & ~(N_REQ'(1) << last_grant));
        at_max       = (lock_cnt == CNT_W'(MAX_LOCK));
        rr_mode      = (state == S_IDLE) || (at_max && others_valid);
        if (rr_mode) begin
            grant_en  = rr_found;
            grant_idx = rr_idx;
        end else begin
            grant_en  = bus.req_valid[last_grant];
            grant_idx = last_grant;
        end
        ready_vec = grant_en ? (N_REQ'(1) << grant_idx) : '0;
        sel_lock  = bus.req_lock[grant_idx];
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == GID_W'(i)) begin
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.req_ready = ready_vec;

    // Arbitration FSM plus the registered RF write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            last_grant   <= GID_W'(N_REQ - 1);
            lock_cnt     <= '0;
            bus.rf_we    <= 1'b0;
            bus.rf_addr  <= '0;
            bus.rf_data  <= '0;
            bus.grant_id <= '0;
            bus.locked   <= 1'b0;
        end else begin
            bus.rf_we <= grant_en;
            if (grant_en) begin
                bus.rf_addr  <= sel_addr;
                bus.rf_data  <= sel_data;
                bus.grant_id <= grant_idx;
            end
            if (rr_mode) begin
                if (grant_en) begin
                    last_grant <= grant_idx;
                end
                if (grant_en && sel_lock) begin
                    state      <= S_LOCKED;
                    lock_cnt   <= CNT_W'(1);
                    bus.locked <= 1'b1;
                end else begin
                    state      <= S_IDLE;
                    lock_cnt   <= '0;
                    bus.locked <= 1'b0;
                end
            end else if (grant_en && sel_lock) begin
                // Owner continues; a full burst with nobody waiting restarts its count.
                lock_cnt <= at_max ? CNT_W'(1) : lock_cnt + 1'b1;
            end else begin
                state      <= S_IDLE;
                lock_cnt   <= '0;
                bus.locked <= 1'b0;
            end
        end
    end

`ifdef RF_ARB_STATS_EN
    // Per-requester saturating transfer counters; a clear beats a same-cycle transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (stat_clr) begin
                    grant_cnt[i*8 +: 8] <= 8'd0;
                end else if (ready_vec[i] && bus.req_valid[i] &&
                             grant_cnt[i*8 +: 8] != 8'hFF) begin
                    grant_cnt[i*8 +: 8] <= grant_cnt[i*8 +: 8] + 8'd1;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus random
// traffic, compared against a rule-level model of the arbitration policy.
module tb_rf_write_arbiter;
    localparam int N_REQ    = 3;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 4;
    localparam int MAX_LOCK = 4;
    localparam int GID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int W        = GID_W + ADDR_W + DATA_W;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rf_write_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef RF_ARB_STATS_EN
    logic               stat_clr;
    logic [N_REQ*8-1:0] grant_cnt;
`endif

    rf_write_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef RF_ARB_STATS_EN
        ,
        .stat_clr (stat_clr),
        .grant_cnt(grant_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Scoreboard of writes accepted but not yet seen on the RF port.
    logic [W-1:0] exp_q[$];

    // Model: who won last, whether a burst is running, how long it is so far.
    int m_last;
    bit m_burst;
    int m_cnt;
    int m_gcnt[N_REQ];
    bit m_clr;
    int last_win;

    task automatic model_reset();
        m_last  = N_REQ - 1;
        m_burst = 1'b0;
        m_cnt   = 0;
        m_clr   = 1'b0;
        for (int i = 0; i < N_REQ; i++) m_gcnt[i] = 0;
        exp_q.delete();
    endtask

    // Apply the arbitration rules to the current inputs; returns winner or -1.
    task automatic model_cycle(output int win);
        bit others;
        others = 1'b0;
        win    = -1;
        for (int j = 0; j < N_REQ; j++)
            if (j != m_last && bus.req_valid[j]) others = 1'b1;
        if (!m_burst || (m_cnt == MAX_LOCK && others)) begin
            for (int k = 1; k <= N_REQ; k++) begin
                if (win < 0 && bus.req_valid[(m_last + k) % N_REQ]) win = (m_last + k) % N_REQ;
            end
            if (win >= 0) m_last = win;
            if (win >= 0 && bus.req_lock[win]) begin
                m_burst = 1'b1;
                m_cnt   = 1;
            end else begin
                m_burst = 1'b0;
                m_cnt   = 0;
            end
        end else if (bus.req_valid[m_last]) begin
            win = m_last;
            if (bus.req_lock[win]) begin
                m_cnt = (m_cnt == MAX_LOCK) ? 1 : m_cnt + 1;
            end else begin
                m_burst = 1'b0;
                m_cnt   = 0;
            end
        end else begin
            m_burst = 1'b0;
            m_cnt   = 0;
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (m_clr) m_gcnt[i] = 0;
            else if (win == i && m_gcnt[i] < 255) m_gcnt[i] = m_gcnt[i] + 1;
        end
    endtask

    task automatic set_req(input int i, input bit v, input bit l, input int a, input int d);
        bus.req_valid[i] = v;
        bus.req_lock[i]  = l;
        bus.req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
        bus.req_data[i*DATA_W +: DATA_W] = DATA_W'(d);
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
    endtask

    // One clock: check ready before the edge, RF port and locked after it.
    // Called at a falling edge, returns at the next falling edge.
    task automatic cycle();
        int win;
        logic [N_REQ-1:0] exp_ready;
        logic [W-1:0] exp_w;
        #1;
        model_cycle(win);
        last_win  = win;
        exp_ready = (win >= 0) ? (N_REQ'(1) << win) : '0;
        tests++;
        if (bus.req_ready !== exp_ready) begin
            fails++;
            $display("FAIL ready: got %b want %b at %0t", bus.req_ready, exp_ready, $time);
        end
        if (win >= 0)
            exp_q.push_back({GID_W'(win), bus.req_addr[win*ADDR_W +: ADDR_W],
                             bus.req_data[win*DATA_W +: DATA_W]});
        @(posedge clk);
        #1;
        tests++;
        if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            if (bus.rf_we !== 1'b1 || {bus.grant_id, bus.rf_addr, bus.rf_data} !== exp_w) begin
                fails++;
                $display("FAIL rf_write: got we=%b gid/addr/data=%h want we=1 %h at %0t",
                         bus.rf_we, {bus.grant_id, bus.rf_addr, bus.rf_data}, exp_w, $time);
            end
        end else if (bus.rf_we !== 1'b0) begin
            fails++;
            $display("FAIL rf_we_idle: got %b want 0 at %0t", bus.rf_we, $time);
        end
        tests++;
        if (bus.locked !== m_burst) begin
            fails++;
            $display("FAIL locked: got %b want %b at %0t", bus.locked, m_burst, $time);
        end
`ifdef RF_ARB_STATS_EN
        for (int i = 0; i < N_REQ; i++) begin
            tests++;
            if (grant_cnt[i*8 +: 8] !== 8'(m_gcnt[i])) begin
                fails++;
                $display("FAIL grant_cnt[%0d]: got %0d want %0d", i, grant_cnt[i*8 +: 8], m_gcnt[i]);
            end
        end
`endif
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_reqs();
`ifdef RF_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_reqs();
`ifdef RF_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        tests++;
        if (bus.rf_we !== 1'b0 || bus.locked !== 1'b0 || bus.rf_addr !== '0 || bus.rf_data !== '0) begin
            fails++;
            $display("FAIL reset_values: we=%b locked=%b addr=%h data=%h want all 0",
                     bus.rf_we, bus.locked, bus.rf_addr, bus.rf_data);
        end
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            cycle();
            tests++;
            if (bus.rf_addr !== '0 || bus.grant_id !== '0) begin
                fails++;
                $display("FAIL idle_after_reset: addr=%h gid=%0d want 0/0", bus.rf_addr, bus.grant_id);
            end
        end
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 1'b0, 3 + i, 8 + i);
        for (int c = 0; c < 7; c++) begin
            cycle();
            tests++;
            if (bus.grant_id !== GID_W'(c % N_REQ) || bus.rf_addr !== ADDR_W'(3 + c % N_REQ)) begin
                fails++;
                $display("FAIL rr_order: cycle %0d gid=%0d addr=%0d want %0d/%0d",
                         c, bus.grant_id, bus.rf_addr, c % N_REQ, 3 + c % N_REQ);
            end
        end
        clear_reqs();
        cycle();
    endtask

    task automatic test_single_requester();
        set_req(1, 1'b1, 1'b0, 7, 9);
        for (int c = 0; c < 6; c++) begin
            cycle();
            tests++;
            if (bus.rf_we !== 1'b1 || bus.rf_addr !== 5'd7 || bus.rf_data !== 4'd9 || bus.grant_id !== 2'd1) begin
                fails++;
                $display("FAIL single_req: we=%b addr=%0d data=%0d gid=%0d want 1/7/9/1",
                         bus.rf_we, bus.rf_addr, bus.rf_data, bus.grant_id);
            end
        end
        clear_reqs();
        cycle();
    endtask

    task automatic test_lock_limit();
        int exp_gid;
        do_reset();
        set_req(0, 1'b1, 1'b1, 1, 1);
        set_req(2, 1'b1, 1'b0, 2, 2);
        for (int c = 0; c < 5; c++) begin
            cycle();
            exp_gid = (c < MAX_LOCK) ? 0 : 2;
            tests++;
            if (bus.rf_we !== 1'b1 || bus.grant_id !== GID_W'(exp_gid)) begin
                fails++;
                $display("FAIL lock_limit: cycle %0d we=%b gid=%0d want 1/%0d",
                         c, bus.rf_we, bus.grant_id, exp_gid);
            end
        end
        clear_reqs();
        cycle();
    endtask

    task automatic test_lock_drop();
        do_reset();
        set_req(0, 1'b1, 1'b1, 4, 4);
        set_req(1, 1'b1, 1'b0, 6, 6);
        cycle();
        cycle();
        set_req(0, 1'b0, 1'b1, 4, 4);
        cycle();
        tests++;
        if (bus.rf_we !== 1'b0 || bus.locked !== 1'b0) begin
            fails++;
            $display("FAIL lock_drop_gap: we=%b locked=%b want 0/0", bus.rf_we, bus.locked);
        end
        cycle();
        tests++;
        if (bus.rf_we !== 1'b1 || bus.grant_id !== 2'd1) begin
            fails++;
            $display("FAIL lock_drop_resume: we=%b gid=%0d want 1/1", bus.rf_we, bus.grant_id);
        end
        clear_reqs();
        cycle();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_req(0, 1'b1, 1'b1, 10, 5);
        set_req(1, 1'b1, 1'b0, 11, 3);
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.rf_we !== 1'b0 || bus.locked !== 1'b0 || bus.rf_addr !== '0) begin
            fails++;
            $display("FAIL reset_mid_burst: we=%b locked=%b addr=%h want 0/0/0",
                     bus.rf_we, bus.locked, bus.rf_addr);
        end
        clear_reqs();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < N_REQ; i++)
            set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 15)));
        for (int c = 0; c < 400; c++) begin
            cycle();
            for (int i = 0; i < N_REQ; i++) begin
                if (last_win == i || !bus.req_valid[i]) begin
                    if ($urandom_range(0, 2) != 0)
                        set_req(i, 1'b1, 1'($urandom_range(0, 3) != 0),
                                int'($urandom_range(0, 31)), int'($urandom_range(0, 15)));
                    else
                        bus.req_valid[i] = 1'b0;
                end
                bus.req_lock[i] = 1'($urandom_range(0, 3) != 0);
            end
        end
        clear_reqs();
        cycle();
    endtask

`ifdef RF_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        set_req(2, 1'b1, 1'b0, 12, 7);
        for (int c = 0; c < 300; c++) cycle();
        tests++;
        if (grant_cnt[2*8 +: 8] !== 8'd255) begin
            fails++;
            $display("FAIL stats_saturate: got %0d want 255", grant_cnt[2*8 +: 8]);
        end
        stat_clr = 1'b1;
        m_clr    = 1'b1;
        cycle();
        stat_clr = 1'b0;
        m_clr    = 1'b0;
        tests++;
        if (grant_cnt[2*8 +: 8] !== 8'd0) begin
            fails++;
            $display("FAIL stats_clear: got %0d want 0", grant_cnt[2*8 +: 8]);
        end
        cycle();
        clear_reqs();
        cycle();
    endtask
`endif

    initial begin
        clear_reqs();
        last_win = -1;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_single_requester();
        test_lock_limit();
        test_lock_drop();
        test_reset_mid_burst();
        test_random();
`ifdef RF_ARB_STATS_EN
        test_stats();
`endif
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d writes never seen, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
